// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_frame_tx serial transmitter.
// State encoding, line levels and counter-width helper.
package piso_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } piso_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
        return w;
    endfunction

endpackage

// File: rtl/piso_baud_cnt.sv
// Bit-period counter: bit_end flags the last clk of each CLKS_PER_BIT span.
// Held at zero by clr; only advances while en is high.
import piso_pkg::*;

module piso_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int unsigned     CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: start, DATA_W bits LSB-first, stop bits.
// Define PISO_PARITY_EN to insert an even-parity bit between data and stop.
import piso_pkg::*;

module piso_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    // One bit counter serves both the data bits and the stop-bit span.
    localparam int unsigned      BIT_MAX   = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int unsigned      BC_W      = cnt_width(BIT_MAX);
    localparam logic [BC_W-1:0]  LAST_DATA = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0]  LAST_STOP = BC_W'(STOP_BITS - 1);

    piso_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
`ifdef PISO_PARITY_EN
    logic              par_q, par_d;
`endif

    logic idle;
    logic accept;
    logic bit_end;
    logic last_stop;

    assign idle       = (state_q == ST_IDLE);
    assign load_ready = idle && !clear;
    assign accept     = load_valid && load_ready;
    assign busy       = !idle;
    assign last_stop  = (state_q == ST_STOP) && bit_end && (bitcnt_q == LAST_STOP);
    assign done       = last_stop && !clear;

    piso_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear || idle),
        .en     (busy),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        if (clear) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d  = ST_START;
                        shreg_d  = load_data;
                        bitcnt_d = '0;
`ifdef PISO_PARITY_EN
                        par_d    = ^load_data;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg_d = shreg_q >> 1;
                        if (bitcnt_q == LAST_DATA) begin
                            bitcnt_d = '0;
`ifdef PISO_PARITY_EN
                            state_d  = ST_PARITY;
`else
                            state_d  = ST_STOP;
`endif
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (bitcnt_q == LAST_STOP) begin
                            state_d  = ST_IDLE;
                            bitcnt_d = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                end
            endcase
        end
    end

    // Line level decoded from registered state only, so reset forces it high at once.
    always_comb begin
        case (state_q)
            ST_START:  sout = START_BIT;
            ST_DATA:   sout = shreg_q[0];
`ifdef PISO_PARITY_EN
            ST_PARITY: sout = par_q;
`endif
            default:   sout = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx: two instances (8/1/4 and 5/2/1 configurations).
module tb_piso_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       lv0 = 1'b0, clr0 = 1'b0;
    logic [7:0] ld0 = '0;
    logic       rdy0, so0, bsy0, dn0;

    logic       lv1 = 1'b0, clr1 = 1'b0;
    logic [4:0] ld1 = '0;
    logic       rdy1, so1, bsy1, dn1;

    int vectors = 0;
    int errors  = 0;

`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic s;
        logic d;
        logic b;
    } ent_t;

    localparam ent_t IDLE_E = 3'b100;

    ent_t q0[$];
    ent_t q1[$];
    ent_t cur0, cur1;
    bit   acc0, acc1;

    piso_frame_tx #(.DATA_W(8), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .reset(rst), .load_valid(lv0), .load_ready(rdy0), .load_data(ld0),
        .clear(clr0), .sout(so0), .busy(bsy0), .done(dn0)
    );

    piso_frame_tx #(.DATA_W(5), .STOP_BITS(2), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(rst), .load_valid(lv1), .load_ready(rdy1), .load_data(ld1),
        .clear(clr1), .sout(so1), .busy(bsy1), .done(dn1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bits(input int i, input logic v, input int n, input bit last);
        for (int k = 0; k < n; k++) begin
            ent_t e;
            e.s = v;
            e.b = 1'b1;
            e.d = last && (k == n - 1);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic push_frame(input int i, input logic [31:0] data);
        int   w   = (i == 0) ? 8 : 5;
        int   sb  = (i == 0) ? 1 : 2;
        int   cpb = (i == 0) ? 4 : 1;
        logic p   = 1'b0;
        push_bits(i, 1'b0, cpb, 1'b0);
        for (int b = 0; b < w; b++) begin
            push_bits(i, data[b], cpb, 1'b0);
            p = p ^ data[b];
        end
        if (PB != 0) push_bits(i, p, cpb, 1'b0);
        push_bits(i, 1'b1, sb * cpb, 1'b1);
    endtask

    task automatic model_edge0();
        acc0 = 1'b0;
        if (rst || clr0) begin
            q0.delete();
            cur0 = IDLE_E;
        end else begin
            if (!cur0.b && q0.size() == 0 && lv0) begin
                push_frame(0, {24'b0, ld0});
                acc0 = 1'b1;
            end
            cur0 = (q0.size() != 0) ? q0.pop_front() : IDLE_E;
        end
    endtask

    task automatic model_edge1();
        acc1 = 1'b0;
        if (rst || clr1) begin
            q1.delete();
            cur1 = IDLE_E;
        end else begin
            if (!cur1.b && q1.size() == 0 && lv1) begin
                push_frame(1, {27'b0, ld1});
                acc1 = 1'b1;
            end
            cur1 = (q1.size() != 0) ? q1.pop_front() : IDLE_E;
        end
    endtask

    task automatic check_all();
        check("sout0", {31'b0, so0},  {31'b0, cur0.s});
        check("busy0", {31'b0, bsy0}, {31'b0, cur0.b});
        check("done0", {31'b0, dn0},  {31'b0, cur0.d & ~clr0});
        check("rdy0",  {31'b0, rdy0}, {31'b0, ~cur0.b & ~clr0});
        check("sout1", {31'b0, so1},  {31'b0, cur1.s});
        check("busy1", {31'b0, bsy1}, {31'b0, cur1.b});
        check("done1", {31'b0, dn1},  {31'b0, cur1.d & ~clr1});
        check("rdy1",  {31'b0, rdy1}, {31'b0, ~cur1.b & ~clr1});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge0();
        model_edge1();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int i, input logic [31:0] d, input bit hold);
        int k   = 0;
        bit got = 1'b0;
        if (i == 0) begin lv0 = 1'b1; ld0 = d[7:0]; end
        else        begin lv1 = 1'b1; ld1 = d[4:0]; end
        while (!got && k < 300) begin
            tick();
            k++;
            got = (i == 0) ? acc0 : acc1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) begin
            if (i == 0) lv0 = 1'b0;
            else        lv1 = 1'b0;
        end
    endtask

    // Reset is raised between clock edges; outputs must respond before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        cur0 = IDLE_E;
        cur1 = IDLE_E;
        check_all();
        run(2);
        rst = 1'b0;
        run(1);
    endtask

    initial begin
        cur0 = IDLE_E;
        cur1 = IDLE_E;
        #1 check_all();
        run(2);
        rst = 1'b0;
        run(2);

        send(0, 32'hA5, 1'b0);
        run(46);
        send(0, 32'h07, 1'b0);
        run(50);

        send(0, 32'h3C, 1'b1);
        send(0, 32'hC3, 1'b0);
        run(50);

        send(0, 32'hFF, 1'b0);
        run(16);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        run(3);
        clr0 = 1'b1; lv0 = 1'b1; ld0 = 8'h11;
        run(2);
        clr0 = 1'b0; lv0 = 1'b0;
        run(2);
        send(0, 32'h00, 1'b0);
        run(50);

        send(0, 32'h5A, 1'b0);
        run(10);
        async_reset();
        run(3);

        send(1, 32'h13, 1'b0);
        lv1 = 1'b1; ld1 = 5'b01010;
        run(3);
        lv1 = 1'b0;
        run(12);
        send(1, 32'h0D, 1'b1);
        send(1, 32'h16, 1'b0);
        run(14);

        async_reset();
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
